// File: rtl/abc_sweep_sequencer.sv
// ============================================================================
// Module   : abc_sweep_sequencer
// Purpose  : Drives a,b,c through 000..111 for DWELL cycles each, samples the
//            {x,y} response at the end of each dwell and counts x==0&&y==0.
//            Optional abort input is enabled by defining SWEEP_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module abc_sweep_sequencer #(
    parameter int DWELL = 20,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
`ifdef SWEEP_ABORT_EN
    input  logic        abort,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic        x,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [2:0]  step_idx,
    output logic [15:0] resp_map,
    output logic [3:0]  zero_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         step_idx_q, step_idx_d;
    logic [15:0]        resp_map_q, resp_map_d;
    logic [3:0]         zero_count_q, zero_count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               abort_req;

`ifdef SWEEP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_idx_d   = step_idx_q;
        resp_map_d   = resp_map_q;
        zero_count_d = zero_count_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    step_idx_d   = 3'd0;
                    resp_map_d   = 16'h0000;
                    zero_count_d = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident sample; partial results stay.
                if (abort_req) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    step_idx_d = 3'd0;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                end else if (cnt_q == c_cnt_last) begin
                    resp_map_d[{step_idx_q, 1'b0} +: 2] = {x, y};
                    if (!x && !y) begin
                        zero_count_d = zero_count_q + 4'd1;
                    end
                    cnt_d = '0;
                    if (step_idx_q == 3'd7) begin
                        state_d    = ST_DONE;
                        step_idx_d = 3'd0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        step_idx_d = step_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                step_idx_d = 3'd0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            step_idx_q   <= 3'd0;
            resp_map_q   <= 16'h0000;
            zero_count_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_idx_q   <= step_idx_d;
            resp_map_q   <= resp_map_d;
            zero_count_q <= zero_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Stimulus bits are taken straight from the registered index.
    assign a          = step_idx_q[2];
    assign b          = step_idx_q[1];
    assign c          = step_idx_q[0];
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign resp_map   = resp_map_q;
    assign zero_count = zero_count_q;

endmodule

`default_nettype wire

// File: doc/abc_sweep_sequencer.md
Name: abc_sweep_sequencer

Overview:
- Hardware stimulus/response stage wrapped around the 3-input, 2-output combinational block (inputs a, b, c; outputs x, y).
- Upstream role: on a start pulse, drives a, b, c through all 8 combinations 000→111, holding each for DWELL cycles.
- Downstream role: samples x, y at the end of each dwell, records a 16-bit response map and counts the vectors where x==0 && y==0.
- Replaces the simulation-only sweep with synthesizable logic usable on the board.

Parameters:
- DWELL, 20, clock cycles each vector is held (legal range 1..255).
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled on the rising edge.
- a  output  1  stimulus bit, MSB of the vector index.
- b  output  1  stimulus bit, middle bit of the vector index.
- c  output  1  stimulus bit, LSB of the vector index.
- x  input  1  response bit from the combinational block.
- y  input  1  response bit from the combinational block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- step_idx  output  3  current vector index.
- resp_map  output  16  {x,y} for vector i held at bits [2i+1:2i].
- zero_count  output  4  number of vectors with x==0 && y==0 (0..8).

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; a=b=c=0; busy=0; done=0; step_idx=0; dwell counter=0; resp_map=16'h0000; zero_count=0. Takes effect mid-sweep with no partial completion.
- All outputs are registered; {a,b,c} == step_idx at all times.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN. Same edge: step_idx=0, cnt=0, resp_map=0, zero_count=0, done=0, busy=1.
- RUN: cnt increments each cycle. At the edge where cnt==DWELL-1:
  - capture resp_map[2*step_idx+1 : 2*step_idx] = {x,y};
  - zero_count += 1 if x==0 && y==0;
  - if step_idx==7: → DONE, busy=0, done=1, step_idx=0 (abc returns to 000);
  - else: step_idx+1, cnt=0.
- Each vector is therefore driven for exactly DWELL cycles and sampled at the end of its last cycle. x, y are assumed settled one cycle after abc changes.
- Total busy time = 8*DWELL cycles. done rises on the same edge as the final sample.
- start while in RUN: ignored; the sweep continues unchanged.
- DONE: done=1 and busy=0; resp_map and zero_count are held stable. start=1 → RUN with the same clearing as from IDLE; done drops on that edge.
- DWELL=1: abc advances every cycle; 8 samples in 8 cycles.
- zero_count saturation is not needed (maximum 8 fits in 4 bits).
- No wrap-around: step_idx never goes 7→0 while in RUN.

Optional Feature:
- Macro: SWEEP_ABORT_EN.
- With SWEEP_ABORT_EN defined:
  - adds port abort (input, 1 bit);
  - abort=1 in RUN → IDLE on the next edge: busy=0, done=0, step_idx=0;
  - resp_map and zero_count keep the partial results gathered so far;
  - abort has priority over a sample/advance occurring on the same edge, so that sample is not recorded;
  - abort is ignored in IDLE and DONE.
- Without the macro: no abort port; a sweep can only be stopped by reset_n.

Test Plan:
- Stand-in DUT x=a&b, y=c, DWELL=20; pulse start → busy high for exactly 160 cycles, then done=1, resp_map=16'hE444, zero_count=3, abc=000.
- Same stand-in, DWELL=1 → 8 busy cycles; step_idx and abc follow 0..7 on consecutive cycles; resp_map=16'hE444.
- Stand-in x=0, y=0 → zero_count=8, resp_map=16'h0000. Then stand-in x=1, y=1 with a restart from DONE → done drops on the start edge; final zero_count=0, resp_map=16'hFFFF.
- Pulse start again at cycle 50 of a DWELL=20 sweep → no restart; done still arrives at cycle 160 with unchanged results.
- Drive reset_n low at cycle 70 mid-sweep → all outputs 0 immediately, without waiting for a clock edge; after release, start runs a full clean sweep.
- With SWEEP_ABORT_EN: abort at cycle 45 (DWELL=20) → IDLE, done=0; resp_map holds vectors 0 and 1 only (16'h0004 with stand-in x=a&b, y=c); zero_count=1.
